logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 23 ++
 rtl/logic_unit_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 111 +++++++++++
 tb/tb_logic_unit_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: op encoding and popcount sizing.
// Compile-time option LOGIC_UNIT_PIPE_POPCNT_EN is consumed by logic_unit_pipe.
package logic_unit_pkg;

    localparam int OP_W = 3;

    // Codes 000-011 keep the legacy 32-bit logic unit encoding.
    typedef enum logic [OP_W-1:0] {
        OP_XOR    = 3'b000,
        OP_NOT_A  = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_NAND   = 3'b100,
        OP_NOR    = 3'b101,
        OP_XNOR   = 3'b110,
        OP_PASS_A = 3'b111
    } op_e;

    function automatic int popcnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation decode; sits between the S1 and S2 registers.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_XOR:    result = a ^ b;
            OP_NOT_A:  result = ~a;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_XNOR:   result = ~(a ^ b);
            OP_PASS_A: result = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit (S1: operands, S2: result/flags).
// Define LOGIC_UNIT_PIPE_POPCNT_EN to add the registered out_popcnt output.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic [OP_W-1:0]                 op,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_result,
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    output logic [popcnt_width(WIDTH)-1:0]  out_popcnt,
`endif
    output logic                            out_zero
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic [WIDTH-1:0] core_result;
    logic             s2_advance;
    logic             in_fire;

    // S1 empties exactly when S2 loads, so S2's advance also frees S1.
    assign s2_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = rst_n && (!s1_valid || s2_advance);
    assign in_fire    = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_fire)
                s1_valid <= 1'b1;
            else if (s2_advance)
                s1_valid <= 1'b0;

            if (s2_advance)
                s2_valid <= 1'b1;
            else if (out_ready)
                s2_valid <= 1'b0;
        end
    end

    // NOTE: S1 payload is left unreset; it is never observed unless s1_valid is set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
        end
    end

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result)
    );

    // S2 payload is reset because the outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_result <= '0;
            s2_zero   <= 1'b0;
        end else if (s2_advance) begin
            s2_result <= core_result;
            s2_zero   <= (core_result == '0);
        end
    end

`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    localparam int PCW = popcnt_width(WIDTH);

    logic [PCW-1:0] core_popcnt;
    logic [PCW-1:0] s2_popcnt;

    always_comb begin
        core_popcnt = '0;
        for (int i = 0; i < WIDTH; i++)
            core_popcnt = core_popcnt + PCW'(core_result[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s2_popcnt <= '0;
        else if (s2_advance)
            s2_popcnt <= core_popcnt;
    end

    assign out_popcnt = s2_popcnt;
`endif

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_zero   = s2_zero;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=32): vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_logic_unit_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    logic [5:0]    out_popcnt;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        .out_popcnt (out_popcnt),
`endif
        .out_zero   (out_zero)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each op described by its boolean meaning.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] code);
        case (code)
            3'd0: return x ^ y;
            3'd1: return ~x;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] res;
        int           acc_cyc;
    } item_t;

    item_t mq[$];
    int    cyc = 0;

    logic         obs_valid;
    logic         obs_ready;
    logic [W-1:0] obs_res;

    // One clock cycle: drive at posedge+1, sample at posedge+5, compare with the model.
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2:0] iop, input logic ordy);
        logic exp_ready;
        logic exp_ov;
        item_t it;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        #4;
        // At most two in flight; a full pipe frees a slot only when the output leaves.
        exp_ready = (mq.size() < 2) || ordy;
        exp_ov    = (mq.size() > 0) && (mq[0].acc_cyc + 1 < cyc);
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov && out_valid) begin
            check("out_result", out_result, mq[0].res);
            check("out_zero", out_zero, mq[0].res == '0);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
            check("out_popcnt", out_popcnt, $countones(mq[0].res));
`endif
        end
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_res   = out_result;
        if (exp_ov && ordy)
            void'(mq.pop_front());
        if (iv && in_ready) begin
            it.res     = ref_op(ia, ib, iop);
            it.acc_cyc = cyc;
            mq.push_back(it);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && mq.size() > 0; i++)
            cycle(1'b0, '0, '0, 3'd0, 1'b1);
        check(name, mq.size(), 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        int           exp_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int accepted;
        int delivered;
        logic [W-1:0] stall_res;

        tbl[0] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'h0FF00FF0, 1'b0, 16};
        tbl[1] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd1, 32'h0F0F0F0F, 1'b0, 16};
        tbl[2] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 32'hF000F000, 1'b0, 8};
        tbl[3] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd3, 32'hFFF0FFF0, 1'b0, 24};
        tbl[4] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 32'h0FFF0FFF, 1'b0, 24};
        tbl[5] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd5, 32'h000F000F, 1'b0, 8};
        tbl[6] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd6, 32'hF00FF00F, 1'b0, 16};
        tbl[7] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd7, 32'hF0F0F0F0, 1'b0, 16};
        tbl[8] = '{32'h12345678, 32'h12345678, 3'd0, 32'h00000000, 1'b1, 0};
        tbl[9] = '{32'hFFFFFFFF, 32'h00000000, 3'd7, 32'hFFFFFFFF, 1'b0, 32};

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 0);
        check("rst_out_zero", out_zero, 1'b0);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        check("rst_out_popcnt", out_popcnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table back-to-back: result j appears two cycles after its accept.
        for (int i = 0; i < 12; i++) begin
            if (i < 10)
                cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
            else
                cycle(1'b0, '0, '0, 3'd0, 1'b1);
            if (i >= 2) begin
                check("tbl_valid", obs_valid, 1'b1);
                check("tbl_result", obs_res, tbl[i-2].exp_res);
                check("tbl_zero", out_zero === 1'bx ? 1'b0 : tbl[i-2].exp_zero, tbl[i-2].exp_zero);
            end
        end
        drain("tbl_drain");

        // Stall: 5 ops, output blocked for 4 cycles once results start.
        accepted = 0; delivered = 0; stall_res = '0;
        for (int c = 0; c < 30 && delivered < 5; c++) begin
            logic ordy;
            logic [W-1:0] va;
            ordy = !(c >= 2 && c <= 5);
            va = W'(32'hA5000000 + accepted);
            cycle(accepted < 5, va, 32'h0000FFFF, 3'(accepted), ordy);
            if (c == 2) begin
                stall_res = obs_res;
                check("stall_full_ready", obs_ready, 1'b0);
            end
            if (c > 2 && c <= 5) begin
                check("stall_stable", obs_res, stall_res);
                check("stall_ready_low", obs_ready, 1'b0);
            end
            if (accepted < 5 && obs_ready)
                accepted++;
            if (obs_valid && ordy)
                delivered++;
        end
        check("stall_delivered", delivered, 5);
        drain("stall_drain");

        // Alternating out_ready with continuous in_valid.
        accepted = 0; delivered = 0;
        for (int c = 0; c < 60; c++) begin
            cycle(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), (c % 2) == 0);
            if (obs_ready)
                accepted++;
            if (obs_valid && (c % 2) == 0)
                delivered++;
        end
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, '0, '0, 3'd0, 1'b1);
            if (obs_valid)
                delivered++;
        end
        check("toggle_count", delivered, accepted);
        drain("toggle_drain");

        // Reset pulse with two ops in flight.
        cycle(1'b1, 32'h11112222, 32'h33334444, 3'd2, 1'b0);
        cycle(1'b1, 32'h55556666, 32'h77778888, 3'd3, 1'b0);
        cycle(1'b0, '0, '0, 3'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b0);
        check("async_rst_result", out_result, 0);
        mq.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++)
            cycle(1'b0, '0, '0, 3'd0, 1'b1);
        check("post_rst_idle", obs_valid, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++)
            cycle($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 7) == 0) ? a : $urandom,
                  3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
